// File: rtl/uart_tx_buf.sv
// UART transmitter: FIFO (push when in_valid && in_ready) feeding a serializer. The line is busy for
// (1+DATA_WIDTH+parity+STOP_BITS)*CLKS_PER_BIT cycles per frame. Define UART_TX_BREAK_EN to add the brk input.
module uart_tx_buf #(
  parameter int DATA_WIDTH   = 8,
  parameter int FIFO_DEPTH   = 4,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_MODE  = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                            clk,
  input  logic                            rst,
`ifdef UART_TX_BREAK_EN
  input  logic                            brk,
`endif
  input  logic [DATA_WIDTH-1:0]           in_data,
  input  logic                            in_valid,
  output logic                            in_ready,
  output logic                            tx,
  output logic                            busy,
  output logic                            tx_done,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count
);
  localparam int CW   = $clog2(FIFO_DEPTH + 1);
  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int DIVW = $clog2(CLKS_PER_BIT);
  localparam int BW   = $clog2(DATA_WIDTH);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]         count_q, count_d;
  state_t                state_q;
  logic [DIVW-1:0]       div_q;
  logic [BW-1:0]         bit_q;
  logic                  stop_q;
  logic [DATA_WIDTH-1:0] shreg_q;
  logic                  par_q, tx_q, busy_q, done_q;
  logic                  push, pop, bit_end, last_stop, idle_go, not_empty;
  logic [DATA_WIDTH-1:0] head;

  assign not_empty = (count_q != '0);
  assign in_ready  = (count_q != CW'(FIFO_DEPTH));
  assign push      = in_valid && in_ready;
  assign head      = mem_q[rd_ptr_q];
  assign bit_end   = (div_q == DIVW'(CLKS_PER_BIT - 1));
  assign last_stop = (stop_q == 1'(STOP_BITS - 1));

`ifdef UART_TX_BREAK_EN
  assign idle_go = not_empty && !brk;
`else
  assign idle_go = not_empty;
`endif

  // Only words already counted are popped, so a same-cycle push cannot be sent before the next edge.
  assign pop = ((state_q == S_IDLE) && idle_go) ||
               ((state_q == S_STOP) && bit_end && last_stop && not_empty);

  assign count_d = count_q + CW'(push) - CW'(pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      div_q   <= '0;
      bit_q   <= '0;
      stop_q  <= 1'b0;
      shreg_q <= '0;
      par_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      div_q  <= bit_end ? '0 : div_q + 1'b1;
      case (state_q)
        S_IDLE: begin
          div_q <= '0;
`ifdef UART_TX_BREAK_EN
          tx_q  <= ~brk;
`else
          tx_q  <= 1'b1;
`endif
        end
        S_START: begin
          if (bit_end) begin
            state_q <= S_DATA;
            tx_q    <= shreg_q[0];
            bit_q   <= '0;
          end
        end
        S_DATA: begin
          if (bit_end) begin
            if (bit_q == BW'(DATA_WIDTH - 1)) begin
              if (PARITY_MODE != 0) begin
                state_q <= S_PARITY;
                tx_q    <= par_q;
              end else begin
                state_q <= S_STOP;
                tx_q    <= 1'b1;
                stop_q  <= 1'b0;
              end
            end else begin
              tx_q    <= shreg_q[1];
              shreg_q <= shreg_q >> 1;
              bit_q   <= bit_q + 1'b1;
            end
          end
        end
        S_PARITY: begin
          if (bit_end) begin
            state_q <= S_STOP;
            tx_q    <= 1'b1;
            stop_q  <= 1'b0;
          end
        end
        S_STOP: begin
          if (bit_end) begin
            if (last_stop) begin
              done_q  <= 1'b1;
              state_q <= S_IDLE;
              tx_q    <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              stop_q <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
          div_q   <= '0;
        end
      endcase
      // A pop overrides the IDLE/STOP exit above and starts the next frame on this edge.
      if (pop) begin
        state_q <= S_START;
        tx_q    <= 1'b0;
        busy_q  <= 1'b1;
        div_q   <= '0;
        shreg_q <= head;
        par_q   <= (^head) ^ (PARITY_MODE == 2);
      end
    end
  end

  assign tx         = tx_q;
  assign busy       = busy_q;
  assign tx_done    = done_q;
  assign fifo_count = count_q;

endmodule

// File: tb/tb_uart_tx_buf.sv
// Directed bench for uart_tx_buf: three instances (no/even/odd parity), CLKS_PER_BIT = 4.
module tb_uart_tx_buf;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int done_cnt0 = 0;

  logic [7:0] in_data0, in_data1, in_data2;
  logic       in_valid0, in_valid1, in_valid2;
  logic       in_ready0, in_ready1, in_ready2;
  logic       tx0, tx1, tx2;
  logic       busy0, busy1, busy2;
  logic       done0, done1, done2;
  logic [2:0] cnt0, cnt1, cnt2;
`ifdef UART_TX_BREAK_EN
  logic       brk0 = 1'b0;
`endif

  always @(posedge clk) cyc++;
  always @(negedge clk) if (done0 === 1'b1) done_cnt0++;

  uart_tx_buf #(.DATA_WIDTH(8), .FIFO_DEPTH(4), .CLKS_PER_BIT(4), .PARITY_MODE(0), .STOP_BITS(1)) u0 (
    .clk(clk), .rst(rst),
`ifdef UART_TX_BREAK_EN
    .brk(brk0),
`endif
    .in_data(in_data0), .in_valid(in_valid0), .in_ready(in_ready0),
    .tx(tx0), .busy(busy0), .tx_done(done0), .fifo_count(cnt0));

  uart_tx_buf #(.DATA_WIDTH(8), .FIFO_DEPTH(4), .CLKS_PER_BIT(4), .PARITY_MODE(1), .STOP_BITS(1)) u1 (
    .clk(clk), .rst(rst),
`ifdef UART_TX_BREAK_EN
    .brk(1'b0),
`endif
    .in_data(in_data1), .in_valid(in_valid1), .in_ready(in_ready1),
    .tx(tx1), .busy(busy1), .tx_done(done1), .fifo_count(cnt1));

  uart_tx_buf #(.DATA_WIDTH(8), .FIFO_DEPTH(4), .CLKS_PER_BIT(4), .PARITY_MODE(2), .STOP_BITS(1)) u2 (
    .clk(clk), .rst(rst),
`ifdef UART_TX_BREAK_EN
    .brk(1'b0),
`endif
    .in_data(in_data2), .in_valid(in_valid2), .in_ready(in_ready2),
    .tx(tx2), .busy(busy2), .tx_done(done2), .fifo_count(cnt2));

  function automatic logic get_tx(input int idx);
    case (idx)
      0:       return tx0;
      1:       return tx1;
      default: return tx2;
    endcase
  endfunction

  // Call at a negedge no later than the first cycle of the start bit; samples mid-bit.
  task automatic rx_frame(input int idx, input bit with_par, output logic [7:0] d,
                          output logic p, output int start_cyc);
    bit seen;
    seen = 1'b0;
    d = 'x;
    p = 'x;
    start_cyc = -1;
    for (int n = 0; n < 400 && !seen; n++) begin
      if (get_tx(idx) === 1'b0) seen = 1'b1;
      else @(negedge clk);
    end
    tests++;
    if (!seen) begin
      fails++;
      $display("FAIL rx_timeout dut%0d: no start bit within 400 cycles", idx);
      return;
    end
    start_cyc = cyc;
    repeat (2) @(negedge clk);
    tests++;
    if (get_tx(idx) !== 1'b0) begin
      fails++;
      $display("FAIL rx_start_mid dut%0d: tx=%b want 0", idx, get_tx(idx));
    end
    for (int i = 0; i < 8; i++) begin
      repeat (4) @(negedge clk);
      d[i] = get_tx(idx);
    end
    if (with_par) begin
      repeat (4) @(negedge clk);
      p = get_tx(idx);
    end
    repeat (4) @(negedge clk);
    tests++;
    if (get_tx(idx) !== 1'b1) begin
      fails++;
      $display("FAIL rx_stop dut%0d: tx=%b want 1", idx, get_tx(idx));
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    in_valid0 = 0; in_valid1 = 0; in_valid2 = 0;
    in_data0 = '0; in_data1 = '0; in_data2 = '0;
    repeat (2) @(negedge clk);
    tests++; if (tx0 !== 1'b1)       begin fails++; $display("FAIL reset_tx: got %b want 1", tx0); end
    tests++; if (busy0 !== 1'b0)     begin fails++; $display("FAIL reset_busy: got %b want 0", busy0); end
    tests++; if (done0 !== 1'b0)     begin fails++; $display("FAIL reset_done: got %b want 0", done0); end
    tests++; if (cnt0 !== 3'd0)      begin fails++; $display("FAIL reset_count: got %0d want 0", cnt0); end
    tests++; if (in_ready0 !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b want 1", in_ready0); end
    tests++; if ({tx1, tx2} !== 2'b11) begin fails++; $display("FAIL reset_tx_par: got %b want 11", {tx1, tx2}); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic;
    logic [9:0]  bits;
    logic [39:0] got, exp;
    bit          early_done;
    bits = 10'b11_0100_1010;  // start, A5 LSB first, stop
    for (int i = 0; i < 40; i++) exp[i] = bits[i / 4];
    early_done = 1'b0;
    in_data0 = 8'hA5; in_valid0 = 1'b1;
    @(negedge clk);
    in_valid0 = 1'b0;
    tests++; if (tx0 !== 1'b1) begin fails++; $display("FAIL basic_not_yet_started: tx=%b want 1", tx0); end
    tests++; if (cnt0 !== 3'd1) begin fails++; $display("FAIL basic_count_after_push: got %0d want 1", cnt0); end
    @(negedge clk);
    tests++; if (busy0 !== 1'b1 || cnt0 !== 3'd0) begin
      fails++; $display("FAIL basic_start: busy=%b count=%0d want 1,0", busy0, cnt0);
    end
    for (int i = 0; i < 40; i++) begin
      if (i > 0) @(negedge clk);
      got[i] = tx0;
      if (done0 !== 1'b0) early_done = 1'b1;
    end
    tests++; if (got !== exp) begin fails++; $display("FAIL basic_bitstream: got %h want %h", got, exp); end
    tests++; if (early_done) begin fails++; $display("FAIL basic_early_done: tx_done=1 want 0 during frame"); end
    @(negedge clk);
    tests++; if (done0 !== 1'b1 || busy0 !== 1'b0 || tx0 !== 1'b1) begin
      fails++; $display("FAIL basic_end: done=%b busy=%b tx=%b want 1,0,1", done0, busy0, tx0);
    end
    @(negedge clk);
    tests++; if (done0 !== 1'b0) begin fails++; $display("FAIL basic_done_width: got %b want 0", done0); end
  endtask

  task automatic test_parity;
    logic [7:0] vec [2];
    logic       exp_even [2];
    logic [7:0] d1, d2;
    logic       p1, p2;
    int         s1, s2;
    vec[0] = 8'h07; exp_even[0] = 1'b1;
    vec[1] = 8'h03; exp_even[1] = 1'b0;
    for (int v = 0; v < 2; v++) begin
      in_data1 = vec[v]; in_data2 = vec[v];
      in_valid1 = 1'b1;  in_valid2 = 1'b1;
      @(negedge clk);
      in_valid1 = 1'b0;  in_valid2 = 1'b0;
      fork
        rx_frame(1, 1'b1, d1, p1, s1);
        rx_frame(2, 1'b1, d2, p2, s2);
      join
      tests++; if (d1 !== vec[v]) begin fails++; $display("FAIL parity_even_data: got %h want %h", d1, vec[v]); end
      tests++; if (p1 !== exp_even[v]) begin fails++; $display("FAIL parity_even_bit: got %b want %b", p1, exp_even[v]); end
      tests++; if (d2 !== vec[v]) begin fails++; $display("FAIL parity_odd_data: got %h want %h", d2, vec[v]); end
      tests++; if (p2 !== ~exp_even[v]) begin fails++; $display("FAIL parity_odd_bit: got %b want %b", p2, ~exp_even[v]); end
      repeat (4) @(negedge clk);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] da, db;
    logic       p;
    int         sa, sb, base;
    base = done_cnt0;
    in_data0 = 8'h11; in_valid0 = 1'b1;
    @(negedge clk);
    in_data0 = 8'h22;
    @(negedge clk);
    in_valid0 = 1'b0;
    tests++; if (cnt0 !== 3'd1) begin fails++; $display("FAIL b2b_push_pop_count: got %0d want 1", cnt0); end
    rx_frame(0, 1'b0, da, p, sa);
    rx_frame(0, 1'b0, db, p, sb);
    tests++; if (da !== 8'h11) begin fails++; $display("FAIL b2b_first_data: got %h want 11", da); end
    tests++; if (db !== 8'h22) begin fails++; $display("FAIL b2b_second_data: got %h want 22", db); end
    tests++; if (sb - sa !== 40) begin fails++; $display("FAIL b2b_gap: got %0d cycles want 40", sb - sa); end
    repeat (6) @(negedge clk);
    tests++; if (done_cnt0 - base !== 2) begin fails++; $display("FAIL b2b_done_pulses: got %0d want 2", done_cnt0 - base); end
  endtask

  task automatic test_fifo_full;
    logic [7:0] vec [6];
    logic [7:0] d;
    logic       p;
    int         s;
    vec[0] = 8'h81; vec[1] = 8'h42; vec[2] = 8'h24;
    vec[3] = 8'h18; vec[4] = 8'hF0; vec[5] = 8'h0F;
    in_data0 = 8'hFF; in_valid0 = 1'b1;
    @(negedge clk);
    in_valid0 = 1'b0;
    repeat (7) @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      tests++; if (in_ready0 !== (i < 4)) begin
        fails++; $display("FAIL full_ready_%0d: got %b want %b", i, in_ready0, (i < 4));
      end
      tests++; if (cnt0 !== ((i < 4) ? 3'(i) : 3'd4)) begin
        fails++; $display("FAIL full_count_%0d: got %0d want %0d", i, cnt0, (i < 4) ? i : 4);
      end
      in_data0 = vec[i]; in_valid0 = 1'b1;
      @(negedge clk);
    end
    in_valid0 = 1'b0;
    tests++; if (cnt0 !== 3'd4 || in_ready0 !== 1'b0) begin
      fails++; $display("FAIL full_hold: count=%0d ready=%b want 4,0", cnt0, in_ready0);
    end
    for (int i = 0; i < 4; i++) begin
      rx_frame(0, 1'b0, d, p, s);
      tests++; if (d !== vec[i]) begin fails++; $display("FAIL full_order_%0d: got %h want %h", i, d, vec[i]); end
    end
    repeat (10) @(negedge clk);
    tests++; if (busy0 !== 1'b0 || cnt0 !== 3'd0) begin
      fails++; $display("FAIL full_drained: busy=%b count=%0d want 0,0", busy0, cnt0);
    end
  endtask

`ifdef UART_TX_BREAK_EN
  task automatic test_break;
    brk0 = 1'b1;
    in_data0 = 8'h55; in_valid0 = 1'b1;
    @(negedge clk);
    in_valid0 = 1'b0;
    repeat (5) @(negedge clk);
    tests++; if (tx0 !== 1'b0 || cnt0 !== 3'd1 || busy0 !== 1'b0) begin
      fails++; $display("FAIL break_hold: tx=%b count=%0d busy=%b want 0,1,0", tx0, cnt0, busy0);
    end
    brk0 = 1'b0;
    @(negedge clk);
    tests++; if (busy0 !== 1'b1 || cnt0 !== 3'd0 || tx0 !== 1'b0) begin
      fails++; $display("FAIL break_release: busy=%b count=%0d tx=%b want 1,0,0", busy0, cnt0, tx0);
    end
    repeat (4) @(negedge clk);
    tests++; if (tx0 !== 1'b1) begin fails++; $display("FAIL break_data0: got %b want 1", tx0); end
    repeat (40) @(negedge clk);
  endtask
`endif

  task automatic test_reset_abort;
    int  base;
    bit  bad;
    in_valid0 = 1'b1;
    in_data0 = 8'h00;
    @(negedge clk);
    in_data0 = 8'h5A;
    @(negedge clk);
    in_data0 = 8'h3C;
    @(negedge clk);
    in_valid0 = 1'b0;
    repeat (16) @(negedge clk);
    tests++; if (tx0 !== 1'b0 || cnt0 !== 3'd2 || busy0 !== 1'b1) begin
      fails++; $display("FAIL abort_pre: tx=%b count=%0d busy=%b want 0,2,1", tx0, cnt0, busy0);
    end
    base = done_cnt0;
    rst = 1'b1;
    #1;
    tests++; if (tx0 !== 1'b1 || busy0 !== 1'b0) begin
      fails++; $display("FAIL abort_async: tx=%b busy=%b want 1,0", tx0, busy0);
    end
    tests++; if (cnt0 !== 3'd0 || in_ready0 !== 1'b1 || done0 !== 1'b0) begin
      fails++; $display("FAIL abort_fifo: count=%0d ready=%b done=%b want 0,1,0", cnt0, in_ready0, done0);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (tx0 !== 1'b1 || busy0 !== 1'b0) bad = 1'b1;
    end
    tests++; if (bad) begin fails++; $display("FAIL abort_quiet: line active after reset, want idle"); end
    tests++; if (done_cnt0 !== base) begin fails++; $display("FAIL abort_no_done: got %0d pulses want 0", done_cnt0 - base); end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_back_to_back();
    test_fifo_full();
`ifdef UART_TX_BREAK_EN
    test_break();
`endif
    test_reset_abort();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
